mux_rr_arbiter: RTL

// - Shares one N-to-1 data mux (the output path) among N requesters.
// - Uses a round-robin grant and a valid/ready handshake on every port.
// - Has a single registered output stage (latency 1) feeding one downstream consumer.
// - Sits between producer lanes and a shared sink; the mux select is driven only by this controller.

---
 rtl/mux_arb_pkg.sv | 27 ++
 rtl/mux_rr_arbiter_mux_n.sv | 24 ++
 rtl/mux_rr_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mux_arb_pkg
//  Description : Shared types, defaults and helpers for the round-robin
//                multiplexer arbiter (mux_rr_arbiter).
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int c_DEFAULT_N = 4;
    localparam int c_DEFAULT_W = 8;

    // IDLE: output register empty; BUSY: output register holds a word;
    // LOCK: grant pinned to the lane currently sending a multi-beat packet.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

    // Round-robin successor of a lane index, wrapping at n.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n
//  Description : Pure combinational N-to-1 word multiplexer. Word i of the
//                packed input occupies bits [i*W +: W].
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n #(
    parameter int N     = 4,
    parameter int W     = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic [N*W-1:0] i_data,
    input  logic [SELW-1:0] i_sel,
    output logic [W-1:0]   o_data
);

    // Select the addressed word.
    always_comb begin
        o_data = i_data[int'(i_sel)*W +: W];
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arbiter
//  Description : Shares one N-to-1 data mux among N valid/ready requesters
//                with a round-robin grant and a single registered output
//                stage (latency 1).
//                Optional packet lock: define MUX_ARB_PACKET_LOCK_EN to add
//                the in_last port and keep the grant on one lane until the
//                end of its packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N      = c_DEFAULT_N,
    parameter int W      = c_DEFAULT_W,
    localparam int SRC_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
`ifdef MUX_ARB_PACKET_LOCK_EN
    input  logic [N-1:0]     in_last,
`endif
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SRC_W-1:0] out_src,
    input  logic             out_ready
);

    arb_state_t       r_state;
    logic [SRC_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [SRC_W-1:0] r_out_src;
`ifdef MUX_ARB_PACKET_LOCK_EN
    logic [SRC_W-1:0] r_lock_id;
`endif

    logic             w_can_load;
    logic             w_any_valid;
    logic             w_transfer;
    logic             w_drain;
    logic [SRC_W-1:0] w_scan;
    logic [SRC_W-1:0] w_grant;
    logic [W-1:0]     w_mux_data;

    assign w_can_load  = !r_out_valid || out_ready;
    assign w_any_valid = |in_valid;
    assign w_drain     = r_out_valid && out_ready;

    // Round-robin scan: first requesting lane starting at ptr, wrapping at N.
    always_comb begin
        logic found;
        int   idx;
        w_scan = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && in_valid[idx]) begin
                w_scan = SRC_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // Grant is the scan result, or the pinned lane while a packet is open.
    always_comb begin
`ifdef MUX_ARB_PACKET_LOCK_EN
        w_grant = (r_state == LOCK) ? r_lock_id : w_scan;
`else
        w_grant = w_scan;
`endif
    end

    // Ready goes only to the granted lane, and only when the output stage can load.
    always_comb begin
        in_ready = '0;
        if (w_can_load && w_any_valid) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    assign w_transfer = w_can_load && w_any_valid && in_valid[w_grant];

    mux_n #(
        .N (N),
        .W (W)
    ) u_mux (
        .i_data (in_data),
        .i_sel  (w_grant),
        .o_data (w_mux_data)
    );

    // FSM, round-robin pointer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
`ifdef MUX_ARB_PACKET_LOCK_EN
            r_lock_id   <= '0;
`endif
        end else begin
            if (w_transfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_src   <= w_grant;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end

`ifdef MUX_ARB_PACKET_LOCK_EN
            if (w_transfer) begin
                if (r_state == LOCK) begin
                    // Pointer stays put inside a packet; last beat releases the lane.
                    if (in_last[w_grant]) begin
                        r_state <= BUSY;
                        r_ptr   <= SRC_W'(next_ptr(32'(r_lock_id), N));
                    end
                end else if (!in_last[w_grant]) begin
                    r_state   <= LOCK;
                    r_lock_id <= w_grant;
                end else begin
                    r_state <= BUSY;
                    r_ptr   <= SRC_W'(next_ptr(32'(w_grant), N));
                end
            end else if (w_drain && r_state == BUSY) begin
                r_state <= IDLE;
            end
`else
            if (w_transfer) begin
                r_state <= BUSY;
                r_ptr   <= SRC_W'(next_ptr(32'(w_grant), N));
            end else if (w_drain) begin
                r_state <= IDLE;
            end
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire
